axis_packet_arbiter: RTL and testbench

Round-robin, packet-granular AXI-Stream arbiter that merges NUM_PORTS byte streams into one byte stream. It sits directly upstream of the UART emitter and feeds its i_tdata/i_tlast/i_tvalid/o_tready input. Each per-core message source connects to its own input port. A grant is held from the first beat to the tlast beat of a packet, so messages from different cores are never interleaved on the UART. The output is buffered by a 2-entry FIFO, which sustains one beat per cycle and has no combinational path from i_tready to any o_tready.

---
 rtl/axis_packet_arbiter.sv | 134 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular AXI-Stream byte arbiter feeding a 2-entry output FIFO.
// A grant is held from the first beat through the tlast beat of a packet.
module axis_packet_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [8*NUM_PORTS-1:0]        i_tdata,
  input  logic [NUM_PORTS-1:0]          i_tlast,
  input  logic [NUM_PORTS-1:0]          i_tvalid,
  output logic [NUM_PORTS-1:0]          o_tready,
  output logic [7:0]                    o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          i_tready,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] o_grant
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         cand_s;
  logic                  found_s;
  logic [NUM_PORTS-1:0]  tready_q, tready_d;
  logic [1:0]            count_q, count_d;
  logic [8:0]            mem0_q, mem1_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic                  accept_s, pop_s;
  logic [7:0]            sel_data_s;
  logic                  sel_last_s;

  assign sel_data_s = i_tdata[{grant_q, 3'b000} +: 8];
  assign sel_last_s = i_tlast[grant_q];
  assign accept_s   = (state_q == LOCKED) & i_tvalid[grant_q] & tready_q[grant_q];
  assign pop_s      = (count_q != 2'd0) & i_tready;

  // Arbitration: round-robin search in IDLE, release the lock on an accepted tlast
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    found_s      = 1'b0;
    cand_s       = grant_q;
    case (state_q)
      IDLE: begin
        for (int i = 1; i <= NUM_PORTS; i++) begin
          cand_s = GW'((int'(last_grant_q) + i) % NUM_PORTS);
          if (!found_s && i_tvalid[cand_s]) begin
            found_s = 1'b1;
            grant_d = cand_s;
            state_d = LOCKED;
          end else begin
            found_s = found_s;
          end
        end
      end
      LOCKED: begin
        if (accept_s && sel_last_s) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO occupancy and the registered per-port ready derived from next-state count
  always_comb begin
    count_d  = count_q;
    tready_d = {NUM_PORTS{1'b0}};
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if ((state_d == LOCKED) && (count_d != 2'd2)) begin
      tready_d[grant_d] = 1'b1;
    end else begin
      tready_d = {NUM_PORTS{1'b0}};
    end
  end

  // State, pointers and FIFO storage
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= {GW{1'b0}};
      last_grant_q <= GW'(NUM_PORTS - 1);
      tready_q     <= {NUM_PORTS{1'b0}};
      count_q      <= 2'd0;
      mem0_q       <= 9'd0;
      mem1_q       <= 9'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tready_q     <= tready_d;
      count_q      <= count_d;
      if (accept_s) begin
        if (wr_ptr_q) begin
          mem1_q <= {sel_last_s, sel_data_s};
        end else begin
          mem0_q <= {sel_last_s, sel_data_s};
        end
        wr_ptr_q <= ~wr_ptr_q;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

  assign o_tready = tready_q;
  assign o_grant  = grant_q;
  assign o_tvalid = (count_q != 2'd0);
  assign o_tdata  = rd_ptr_q ? mem1_q[7:0] : mem0_q[7:0];
  assign o_tlast  = rd_ptr_q ? mem1_q[8]   : mem0_q[8];

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed testbench for axis_packet_arbiter (NUM_PORTS=4): reset, single packet,
// fairness, backpressure, lock across gaps and mid-packet reset.
module tb_axis_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_tdata;
  logic [3:0]  i_tlast, i_tvalid, o_tready;
  logic [7:0]  o_tdata;
  logic        o_tlast, o_tvalid, i_tready;
  logic [1:0]  o_grant;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_PORTS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_grant(o_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int b[4];
  int pk[4];
  logic [8:0] got[$];
  int gotcyc[$];
  logic [7:0] rx[$];
  logic [3:0] acc;
  logic pop, prev_stall;
  logic [7:0] prev_data;
  int idx, mcnt, k;

  initial begin
    rst_n = 1'b0; i_tdata = 32'd0; i_tlast = 4'd0; i_tvalid = 4'd0; i_tready = 1'b1;
    // reset then idle
    step(); step(); step();
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_tready", o_tready, 4'd0);
    chk("rst_grant", o_grant, 2'd0);
    chk("rst_tdata", {o_tlast, o_tdata}, 9'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_out", {o_tvalid, o_tready}, 5'd0);
    end

    // single packet on port 2
    i_tvalid = 4'b0100; i_tdata[23:16] = 8'h48; i_tlast = 4'b0000;
    step();
    chk("sp_tready", o_tready, 4'b0100);
    chk("sp_grant", o_grant, 2'd2);
    chk("sp_novalid", o_tvalid, 1'b0);
    step();
    chk("sp_b0", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b0, 8'h48});
    i_tdata[23:16] = 8'h69;
    step();
    chk("sp_b1", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b0, 8'h69});
    i_tdata[23:16] = 8'h0A; i_tlast = 4'b0100;
    step();
    chk("sp_b2", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, 8'h0A});
    chk("sp_drop", o_tready, 4'd0);
    i_tvalid = 4'd0; i_tlast = 4'd0;
    step();
    chk("sp_empty", o_tvalid, 1'b0);

    // fairness: fresh reset so port 0 wins first
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin b[p] = 0; pk[p] = 0; end
    for (int c = 0; c < 80 && got.size() < 16; c++) begin
      for (int p = 0; p < 4; p++) begin
        i_tvalid[p] = (pk[p] < 2);
        i_tlast[p]  = (b[p] == 1);
        i_tdata[8*p +: 8] = (b[p] == 1) ? (8'h80 | 8'(p)) : 8'(p);
      end
      acc = i_tvalid & o_tready;
      if (o_tvalid) begin
        got.push_back({o_tlast, o_tdata});
        gotcyc.push_back(c);
      end
      step();
      for (int p = 0; p < 4; p++) begin
        if (acc[p]) begin
          if (b[p] == 1) pk[p]++;
          b[p] = 1 - b[p];
        end
      end
      chk("fair_onehot", ($countones(o_tready) <= 1), 1'b1);
    end
    i_tvalid = 4'd0; i_tlast = 4'd0;
    chk("fair_count", got.size(), 16);
    if (got.size() == 16) begin
      for (int p = 0; p < 8; p++) begin
        k = p % 4;
        chk("fair_b0", got[2*p], {1'b0, 8'(k)});
        chk("fair_b1", got[2*p+1], {1'b1, 8'h80 | 8'(k)});
      end
      chk("fair_span", gotcyc[15] - gotcyc[0], 22);
    end
    step(); step(); step();

    // backpressure on port 1
    idx = 0; mcnt = 0; prev_stall = 1'b0; prev_data = 8'd0;
    for (int c = 0; c < 100 && rx.size() < 8; c++) begin
      i_tready = (c % 3 == 0);
      i_tvalid = (idx < 8) ? 4'b0010 : 4'b0000;
      i_tdata[15:8] = 8'(idx);
      i_tlast = (idx == 7) ? 4'b0010 : 4'b0000;
      acc = i_tvalid & o_tready;
      pop = o_tvalid & i_tready;
      if (pop) rx.push_back(o_tdata);
      prev_stall = o_tvalid & ~i_tready;
      prev_data = o_tdata;
      step();
      if (acc[1]) begin idx++; mcnt++; end
      if (pop) mcnt--;
      chk("bp_tvalid", o_tvalid, (mcnt != 0));
      if (mcnt == 2) chk("bp_full_ready", o_tready[1], 1'b0);
      if (prev_stall) chk("bp_hold", o_tdata, prev_data);
    end
    i_tvalid = 4'd0; i_tlast = 4'd0; i_tready = 1'b1;
    chk("bp_count", rx.size(), 8);
    for (int p = 0; p < 8 && p < rx.size(); p++) chk("bp_data", rx[p], 8'(p));
    step(); step();

    // lock across gaps: port 0 holds grant while port 3 waits
    i_tvalid = 4'b0001; i_tdata[7:0] = 8'hAA; i_tlast = 4'b0000;
    step();
    chk("lk_grant0", {o_grant, o_tready}, {2'd0, 4'b0001});
    i_tvalid = 4'b1001; i_tdata[31:24] = 8'h33; i_tlast = 4'b1000;
    step();
    chk("lk_aa", {o_tvalid, o_tdata}, {1'b1, 8'hAA});
    i_tvalid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("lk_gap_ready", o_tready, 4'b0001);
    end
    i_tvalid = 4'b1001; i_tdata[7:0] = 8'hBB; i_tlast = 4'b1001;
    step();
    chk("lk_bb", {o_tlast, o_tdata}, {1'b1, 8'hBB});
    chk("lk_release", o_tready, 4'd0);
    i_tvalid = 4'b1000;
    step();
    chk("lk_grant3", {o_grant, o_tready}, {2'd3, 4'b1000});
    step();
    chk("lk_33", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, 8'h33});
    i_tvalid = 4'd0; i_tlast = 4'd0;
    step(); step();

    // reset mid-packet from port 1
    i_tvalid = 4'b0010; i_tdata[15:8] = 8'h10;
    step();
    chk("mr_grant1", o_tready, 4'b0010);
    step();
    i_tdata[15:8] = 8'h11;
    step();
    chk("mr_valid", {o_tvalid, o_tdata}, {1'b1, 8'h11});
    rst_n = 1'b0; i_tvalid = 4'b0011; i_tdata[7:0] = 8'h01;
    step();
    chk("mr_rst_out", {o_tvalid, o_tready, o_grant}, 7'd0);
    rst_n = 1'b1;
    step();
    chk("mr_port0_first", {o_grant, o_tready}, {2'd0, 4'b0001});
    i_tvalid = 4'd0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
